// File: rtl/cpu_pkg.sv
// Shared fetch-path definitions: widths, special instruction words, fetch FSM encoding
// and small PC/counter helpers used by the IF stage.
package cpu_pkg;
    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;
    localparam int CNT_W   = 16;

    localparam logic [ADDR_W-1:0]  PC_STEP    = 8'd4;
    localparam logic [ADDR_W-1:0]  ALIGN_MASK = 8'hFC;
    localparam logic [INSTR_W-1:0] NOP_WORD   = 16'h0000;
    localparam logic [INSTR_W-1:0] HALT_WORD  = 16'h0000;
    localparam logic [CNT_W-1:0]   CNT_MAX    = 16'hFFFF;

    typedef enum logic {
        FS_RUN    = 1'b0,
        FS_HALTED = 1'b1
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_SEL_HOLD     = 2'b00,
        PC_SEL_STEP     = 2'b01,
        PC_SEL_REDIRECT = 2'b10
    } pc_sel_t;

    typedef enum logic [1:0] {
        IFID_HOLD   = 2'b00,
        IFID_LOAD   = 2'b01,
        IFID_BUBBLE = 2'b10
    } ifid_op_t;

    // Word-align a redirect target (low two bits cleared).
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

    // Saturating increment for the delivered-instruction counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] res;
        if (cnt == CNT_MAX) begin
            res = cnt;
        end else begin
            res = cnt + 16'd1;
        end
        return res;
    endfunction
endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with its next-PC selection (hold / step / aligned redirect).
// Arithmetic wraps modulo 2^ADDR_W by construction of the register width.
module fetch_pc_reg
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  pc_sel_t           pc_sel,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] pc
);
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_nxt_s;

    // Next-PC mux.
    always_comb begin
        pc_nxt_s = pc_r;
        case (pc_sel)
            PC_SEL_STEP:     pc_nxt_s = pc_r + PC_STEP;
            PC_SEL_REDIRECT: pc_nxt_s = align_pc(redirect_addr);
            PC_SEL_HOLD:     pc_nxt_s = pc_r;
            default:         pc_nxt_s = pc_r;
        endcase
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_nxt_s;
        end
    end

    assign pc = pc_r;
endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: drives the combinational instruction ROM from the PC and captures the returned
// word into the IF/ID register, handling stall, redirect, wrap and halt-on-terminator.
module instruction_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
    parameter bit                HALT_EN  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  inst_addr,
    input  logic [INSTR_W-1:0] inst_data,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  if_pc_next,
    output logic               if_valid,
    output logic               halted,
    output logic [CNT_W-1:0]   fetch_count
);
    fetch_state_t       state_r;
    fetch_state_t       state_nxt_s;
    pc_sel_t            pc_sel_s;
    ifid_op_t           ifid_op_s;
    logic               halt_hit_s;
    logic [ADDR_W-1:0]  pc_s;
    logic [INSTR_W-1:0] if_instr_r;
    logic [ADDR_W-1:0]  if_pc_r;
    logic [ADDR_W-1:0]  if_pc_next_r;
    logic               if_valid_r;
    logic [CNT_W-1:0]   fetch_count_r;

    assign halt_hit_s = HALT_EN && (inst_data == HALT_WORD);

    fetch_pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc (
        .clk           (clk),
        .rst           (rst),
        .pc_sel        (pc_sel_s),
        .redirect_addr (redirect_addr),
        .pc            (pc_s)
    );

    // Fetch FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= FS_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Fetch FSM next state: redirect beats stall beats the terminator check.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            FS_RUN: begin
                if (redirect_valid) begin
                    state_nxt_s = FS_RUN;
                end else if (stall) begin
                    state_nxt_s = FS_RUN;
                end else if (halt_hit_s) begin
                    state_nxt_s = FS_HALTED;
                end else begin
                    state_nxt_s = FS_RUN;
                end
            end
            FS_HALTED: begin
                if (redirect_valid) begin
                    state_nxt_s = FS_RUN;
                end else begin
                    state_nxt_s = FS_HALTED;
                end
            end
            default: state_nxt_s = FS_RUN;
        endcase
    end

    // Fetch FSM outputs: PC selection and IF/ID register operation.
    always_comb begin
        pc_sel_s  = PC_SEL_HOLD;
        ifid_op_s = IFID_HOLD;
        case (state_r)
            FS_RUN: begin
                if (redirect_valid) begin
                    pc_sel_s  = PC_SEL_REDIRECT;
                    ifid_op_s = IFID_BUBBLE;
                end else if (stall) begin
                    pc_sel_s  = PC_SEL_HOLD;
                    ifid_op_s = IFID_HOLD;
                end else if (halt_hit_s) begin
                    pc_sel_s  = PC_SEL_HOLD;
                    ifid_op_s = IFID_BUBBLE;
                end else begin
                    pc_sel_s  = PC_SEL_STEP;
                    ifid_op_s = IFID_LOAD;
                end
            end
            FS_HALTED: begin
                // IF/ID already holds a bubble; only the PC moves on a restart.
                if (redirect_valid) begin
                    pc_sel_s = PC_SEL_REDIRECT;
                end else begin
                    pc_sel_s = PC_SEL_HOLD;
                end
                ifid_op_s = IFID_HOLD;
            end
            default: begin
                pc_sel_s  = PC_SEL_HOLD;
                ifid_op_s = IFID_HOLD;
            end
        endcase
    end

    // IF/ID pipeline register and delivered-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_instr_r    <= NOP_WORD;
            if_pc_r       <= 8'h00;
            if_pc_next_r  <= 8'h00;
            if_valid_r    <= 1'b0;
            fetch_count_r <= 16'h0000;
        end else begin
            case (ifid_op_s)
                IFID_LOAD: begin
                    if_instr_r    <= inst_data;
                    if_pc_r       <= pc_s;
                    if_pc_next_r  <= pc_s + PC_STEP;
                    if_valid_r    <= 1'b1;
                    fetch_count_r <= sat_inc(fetch_count_r);
                end
                IFID_BUBBLE: begin
                    if_instr_r <= NOP_WORD;
                    if_valid_r <= 1'b0;
                end
                IFID_HOLD: begin
                    if_valid_r <= if_valid_r;
                end
                default: begin
                    if_valid_r <= if_valid_r;
                end
            endcase
        end
    end

    assign inst_addr   = pc_s;
    assign if_instr    = if_instr_r;
    assign if_pc       = if_pc_r;
    assign if_pc_next  = if_pc_next_r;
    assign if_valid    = if_valid_r;
    assign halted      = (state_r == FS_HALTED);
    assign fetch_count = fetch_count_r;
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage coupled to a program ROM; directed scenarios plus a
// randomized run checked against a behavioural model of the fetch rules.
module tb_instruction_fetch_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [7:0]  redirect_addr;
    logic [7:0]  inst_addr, inst_addr1;
    logic [15:0] inst_data, inst_data1;
    logic [15:0] if_instr, if_instr1;
    logic [7:0]  if_pc, if_pc1, if_pc_next, if_pc_next1;
    logic        if_valid, if_valid1, halted, halted1;
    logic [15:0] fetch_count, fetch_count1;
    logic [15:0] rom_mem [0:63];
    logic [57:0] obs, obs1, exp_v;

    int errors = 0;
    int checks = 0;

    // Behavioural model of the halting DUT.
    int m_pc, m_ifpc, m_ifpcn, m_count;
    logic [15:0] m_instr;
    bit m_valid, m_halted;

    always #5 clk = ~clk;

    assign inst_data  = rom_mem[inst_addr[7:2]];
    assign inst_data1 = rom_mem[inst_addr1[7:2]];
    assign obs  = {if_instr, if_pc, if_pc_next, if_valid, halted, fetch_count, inst_addr};
    assign obs1 = {if_instr1, if_pc1, if_pc_next1, if_valid1, halted1, fetch_count1, inst_addr1};

    instruction_fetch_stage #(.RESET_PC(8'h00), .HALT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .inst_addr(inst_addr), .inst_data(inst_data),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .if_instr(if_instr), .if_pc(if_pc), .if_pc_next(if_pc_next),
        .if_valid(if_valid), .halted(halted), .fetch_count(fetch_count));

    instruction_fetch_stage #(.RESET_PC(8'h00), .HALT_EN(1'b0)) dut_nohalt (
        .clk(clk), .rst(rst), .inst_addr(inst_addr1), .inst_data(inst_data1),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .if_instr(if_instr1), .if_pc(if_pc1), .if_pc_next(if_pc_next1),
        .if_valid(if_valid1), .halted(halted1), .fetch_count(fetch_count1));

    function automatic logic [57:0] model_vec();
        logic [7:0] pc8, ifpc8, ifpcn8;
        logic [15:0] cnt16;
        pc8 = m_pc[7:0];
        ifpc8 = m_ifpc[7:0];
        ifpcn8 = m_ifpcn[7:0];
        cnt16 = m_count[15:0];
        return {m_instr, ifpc8, ifpcn8, m_valid, m_halted, cnt16, pc8};
    endfunction

    // Apply one clock edge of the fetch rules to the model, using the current inputs.
    task automatic model_edge();
        logic [15:0] w;
        if (rst) begin
            m_pc = 0; m_ifpc = 0; m_ifpcn = 0; m_count = 0;
            m_instr = 16'h0000; m_valid = 1'b0; m_halted = 1'b0;
        end else if (redirect_valid) begin
            m_pc = (int'(redirect_addr) / 4) * 4;
            if (!m_halted) begin
                m_valid = 1'b0;
                m_instr = 16'h0000;
            end
            m_halted = 1'b0;
        end else if (m_halted || stall) begin
            m_pc = m_pc;
        end else begin
            w = rom_mem[m_pc / 4];
            if (w == 16'h0000) begin
                m_halted = 1'b1;
                m_valid = 1'b0;
                m_instr = 16'h0000;
            end else begin
                m_instr = w;
                m_ifpc = m_pc;
                m_ifpcn = (m_pc + 4) % 256;
                m_valid = 1'b1;
                m_pc = (m_pc + 4) % 256;
                if (m_count < 65535) m_count = m_count + 1;
            end
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit r, input bit st, input bit rv, input logic [7:0] ra);
        rst = r; stall = st; redirect_valid = rv; redirect_addr = ra;
    endtask

    task automatic test_reset();
        set_in(1'b1, 1'b0, 1'b0, 8'h00);
        cycle();
        cycle();
        exp_v = {16'h0000, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_state: got %h want %h", obs, exp_v); end
        checks++;
        if (obs1 !== exp_v) begin errors++; $display("FAIL reset_state_nohalt: got %h want %h", obs1, exp_v); end
    endtask

    task automatic test_run();
        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        cycle();
        exp_v = {16'hABC1, 8'h00, 8'h04, 1'b1, 1'b0, 16'd1, 8'h04};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL run_edge1: got %h want %h", obs, exp_v); end
        cycle();
        exp_v = {16'h5A10, 8'h04, 8'h08, 1'b1, 1'b0, 16'd2, 8'h08};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL run_edge2: got %h want %h", obs, exp_v); end
        cycle();
    endtask

    task automatic test_stall();
        exp_v = {16'h8FFF, 8'h08, 8'h0C, 1'b1, 1'b0, 16'd3, 8'h0C};
        set_in(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL stall_hold_%0d: got %h want %h", i, obs, exp_v); end
        end
        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        cycle();
        exp_v = {16'h3B80, 8'h0C, 8'h10, 1'b1, 1'b0, 16'd4, 8'h10};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL stall_release: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_redirect();
        set_in(1'b0, 1'b1, 1'b1, 8'h3C);
        cycle();
        exp_v = {16'h0000, 8'h0C, 8'h10, 1'b0, 1'b0, 16'd4, 8'h3C};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL redirect_bubble: got %h want %h", obs, exp_v); end
        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        cycle();
        exp_v = {16'hBB80, 8'h3C, 8'h40, 1'b1, 1'b0, 16'd5, 8'h40};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL redirect_target: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_align_wrap();
        set_in(1'b0, 1'b0, 1'b1, 8'h3E);
        cycle();
        checks++;
        if (inst_addr !== 8'h3C) begin errors++; $display("FAIL misaligned_redirect: got %h want %h", inst_addr, 8'h3C); end
        set_in(1'b0, 1'b0, 1'b1, 8'hFC);
        cycle();
        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        cycle();
        exp_v = {16'hC03F, 8'hFC, 8'h00, 1'b1, 1'b0, 16'd6, 8'h00};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL pc_wrap: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_halt();
        set_in(1'b0, 1'b0, 1'b1, 8'h40);
        cycle();
        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        cycle();
        cycle();
        cycle();
        exp_v = {16'h0000, 8'h44, 8'h48, 1'b0, 1'b1, 16'd8, 8'h48};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL halt_enter: got %h want %h", obs, exp_v); end
        exp_v = {16'h0000, 8'h48, 8'h4C, 1'b1, 1'b0, 16'd9, 8'h4C};
        checks++;
        if (obs1 !== exp_v) begin errors++; $display("FAIL halt_disabled_delivers: got %h want %h", obs1, exp_v); end
        exp_v = {16'h0000, 8'h44, 8'h48, 1'b0, 1'b1, 16'd8, 8'h48};
        for (int i = 0; i < 10; i++) begin
            stall = 1'($urandom_range(0, 1));
            cycle();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL halt_hold_%0d: got %h want %h", i, obs, exp_v); end
        end
        set_in(1'b0, 1'b0, 1'b1, 8'h00);
        cycle();
        exp_v = {16'h0000, 8'h44, 8'h48, 1'b0, 1'b0, 16'd8, 8'h00};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL halt_restart: got %h want %h", obs, exp_v); end
        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        cycle();
        exp_v = {16'hABC1, 8'h00, 8'h04, 1'b1, 1'b0, 16'd9, 8'h04};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL halt_first_fetch: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_reset_override();
        exp_v = {16'h0000, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00};
        set_in(1'b0, 1'b1, 1'b0, 8'h00);
        cycle();
        set_in(1'b1, 1'b1, 1'b0, 8'h00);
        cycle();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_mid_stall: got %h want %h", obs, exp_v); end
        set_in(1'b0, 1'b0, 1'b1, 8'h48);
        cycle();
        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        cycle();
        checks++;
        if (halted !== 1'b1) begin errors++; $display("FAIL reset_prep_halt: got %b want %b", halted, 1'b1); end
        set_in(1'b1, 1'b0, 1'b1, 8'h80);
        cycle();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_in_halt: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 7) == 0), 8'($urandom_range(0, 255)));
            cycle();
            exp_v = model_vec();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL random_%0d: got %h want %h", i, obs, exp_v); end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom_mem[i] = 16'hC000 | 16'(i);
        rom_mem[0]  = 16'hABC1;
        rom_mem[1]  = 16'h5A10;
        rom_mem[2]  = 16'h8FFF;
        rom_mem[3]  = 16'h3B80;
        rom_mem[15] = 16'hBB80;
        rom_mem[18] = 16'h0000;
        rom_mem[40] = 16'h0000;
        set_in(1'b1, 1'b0, 1'b0, 8'h00);
        test_reset();
        test_run();
        test_stall();
        test_redirect();
        test_align_wrap();
        test_halt();
        test_reset_override();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
